// File: rtl/pipeline_collect.sv
// Collects one payload per channel into per-channel slots and presents the complete set downstream.
// Optional macro PIPELINE_COLLECT_BYPASS_EN lets slots refill during the cycle the set is consumed.
module pipeline_collect #(
    parameter int N  = 2,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid [N],
    output logic          i_ready [N],
    input  logic [DW-1:0] i_data  [N],
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data  [N]
);

    logic [N-1:0]  full;
    logic [DW-1:0] slot_data [N];
    logic [N-1:0]  i_fire;
    logic          o_fire;

    // o_valid comes from slot flags only, so no input valid can reach it combinationally.
    assign o_valid = &full;
    assign o_fire  = o_valid && o_ready;

    always_comb begin
        for (int i = 0; i < N; i++) begin
`ifdef PIPELINE_COLLECT_BYPASS_EN
            i_ready[i] = !full[i] || o_fire;
`else
            i_ready[i] = !full[i];
`endif
            i_fire[i] = i_valid[i] && i_ready[i];
            o_data[i] = slot_data[i];
        end
    end

    // NOTE: payload registers are reset too, because o_data must read zero right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
            for (int i = 0; i < N; i++) slot_data[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i_fire[i]) begin
                    slot_data[i] <= i_data[i];
                    full[i]      <= 1'b1;
                end else if (o_fire) begin
                    full[i]      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/pipeline_collect.md
PIPELINE_COLLECT -- requirements
Module: pipeline_collect

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning number of input channels (N >= 1).
REQ-002 The block SHALL have parameter DW, default 32, meaning payload width per channel in bits.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port i_valid  input  1 x N (unpacked [N])  per-channel payload valid.
REQ-006 The block SHALL have port i_ready  output  1 x N (unpacked [N])  per-channel slot can accept.
REQ-007 The block SHALL have port i_data  input  DW x N (unpacked [N])  per-channel payload.
REQ-008 The block SHALL have port o_valid  output  1  complete collected set available.
REQ-009 The block SHALL have port o_ready  input  1  downstream accepts collected set.
REQ-010 The block SHALL have port o_data  output  DW x N (unpacked [N])  collected payloads, index i from channel i.

Function
REQ-011 Each channel i SHALL own one slot: flag full[i] and register buf[i] (DW bits).
REQ-012 Channel handshake i_fire[i] = i_valid[i] && i_ready[i]; output handshake o_fire = o_valid && o_ready.
REQ-013 On i_fire[i], buf[i] SHALL capture i_data[i] and full[i] SHALL become 1 at the next edge.
REQ-014 o_valid SHALL equal the AND of full[0..N-1], combinationally from registers only (no combinational path from any i_valid).
REQ-015 o_data[i] SHALL equal buf[i]; o_data SHALL hold stable while o_valid && !o_ready.
REQ-016 On o_fire, all full[i] SHALL clear at the next edge unless refilled per REQ-026.
REQ-017 A full slot SHALL NOT be overwritten; i_ready[i] SHALL be 0 while full[i] and no o_fire.
REQ-018 Channels SHALL fill independently in any order and any cycle spacing; partial sets SHALL wait indefinitely.
REQ-019 Latency: set completed at edge k SHALL show o_valid=1 in cycle k (after the last slot's capture edge), i.e. one cycle after the last i_fire.
REQ-020 i_ready[i] SHALL NOT depend on i_valid of any channel.
REQ-021 With N=1 the block SHALL behave as a single-entry register slice.

Reset
REQ-022 While rst=1 at a rising edge, all full[i] SHALL clear to 0 and all buf[i] to 0.
REQ-023 After reset, o_valid=0, o_data all 0, every i_ready[i]=1 (first cycle after rst deasserts).
REQ-024 Reset asserted mid-collection SHALL discard partial sets; i_fire in a reset cycle SHALL be ignored.

Configuration
REQ-025 Macro PIPELINE_COLLECT_BYPASS_EN SHALL select the refill policy.
REQ-026 Defined: i_ready[i] = !full[i] || o_fire; a channel firing in an o_fire cycle SHALL refill its slot (full[i] stays 1, buf[i] takes new data); full throughput, one set per cycle.
REQ-027 Undefined: i_ready[i] = !full[i]; slots refill only the cycle after o_fire; max throughput one set per two cycles; no combinational o_ready-to-i_ready path.

Verification
REQ-028 N=2, DW=8: reset, then i_data[0]=8'hA5 cycle 1, i_data[1]=8'h3C cycle 4, o_ready=1 -> o_valid=1 only in cycle 5, o_data='{A5,3C}, i_ready[0]=0 cycles 2-5.
REQ-029 Both channels valid same cycle with 8'h11/8'h22, o_ready=0 for 3 cycles -> o_valid held 1, o_data stable '{11,22}, i_ready both 0, new i_data ignored.
REQ-030 Reset pulse after channel 0 captured 8'h77 only -> after reset full cleared, o_data '{00,00}, o_valid=0, i_ready both 1.
REQ-031 Continuous valid on both channels, o_ready=1, 10 sets with incrementing data -> with BYPASS_EN 10 sets in 11 cycles, without 10 sets in 20 cycles, data in order, none lost or duplicated.
REQ-032 Channel 1 valid while channel 0 idle for 6 cycles, then channel 0 valid -> o_valid rises exactly one cycle after channel 0 capture, channel 1 data from its first capture preserved.
REQ-033 Random o_ready/i_valid for 10000 cycles against a scoreboard -> every output set equals per-channel input order, no payload dropped.
